nodeset_req_router: RTL and testbench



---
 rtl/nodeset_req_router.sv | 104 ++++++++++
 tb/tb_nodeset_req_router.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nodeset_req_router.sv
// Request crossbar between nodesets: per-destination round-robin arbitration,
// same-cycle source ack, one-cycle registered delivery of payload and local tag.
module nodeset_req_router #(
    parameter int NUM_NODESETS = 8,
    parameter int NUM_PATHS_DW = 16
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic [NUM_NODESETS-1:0]                    i_src_vld,
    input  logic [NUM_NODESETS*(NUM_PATHS_DW+2)-1:0]   i_src_payload,
    input  logic [NUM_NODESETS*12-1:0]                 i_src_nodenum,
    output logic [NUM_NODESETS-1:0]                    o_src_ack,
    output logic [NUM_NODESETS-1:0]                    o_dst_vld,
    output logic [NUM_NODESETS*(NUM_PATHS_DW+2)-1:0]   o_dst_payload,
    output logic [NUM_NODESETS*6-1:0]                  o_dst_nodenum,
    output logic                                       o_idle,
    output logic                                       o_bad_tag
);
    localparam int unsigned PW   = NUM_PATHS_DW + 2;
    localparam int unsigned PTRW = $clog2(NUM_NODESETS);
    localparam int unsigned TAGW = 12;
    localparam int unsigned LTW  = 6;

    logic [LTW-1:0]          src_dst       [NUM_NODESETS];
    logic [NUM_NODESETS-1:0] src_bad;
    logic [PTRW-1:0]         r_ptr         [NUM_NODESETS];
    logic [PTRW-1:0]         ptr_nxt       [NUM_NODESETS];
    logic [NUM_NODESETS-1:0] cand          [NUM_NODESETS];
    logic [NUM_NODESETS-1:0] cand_hi       [NUM_NODESETS];
    logic [NUM_NODESETS-1:0] pick          [NUM_NODESETS];
    logic [NUM_NODESETS-1:0] grant_vld;
    logic [NUM_NODESETS-1:0] grant_ack;
    logic [PW-1:0]           grant_payload [NUM_NODESETS];
    logic [LTW-1:0]          grant_lcl     [NUM_NODESETS];

    // Destination decode and out-of-range tag detection
    always_comb begin
        src_bad = '0;
        for (int k = 0; k < NUM_NODESETS; k++) begin
            src_dst[k] = i_src_nodenum[k*TAGW+LTW +: LTW];
            src_bad[k] = i_src_vld[k] && ({1'b0, src_dst[k]} >= 7'(NUM_NODESETS));
        end
    end

    // Rotating priority: prefer the lowest candidate at or above the pointer,
    // otherwise wrap to the lowest candidate overall.
    always_comb begin
        grant_vld = '0;
        grant_ack = '0;
        for (int d = 0; d < NUM_NODESETS; d++) begin
            ptr_nxt[d]       = r_ptr[d];
            grant_payload[d] = '0;
            grant_lcl[d]     = '0;
            cand[d]          = '0;
            cand_hi[d]       = '0;
            pick[d]          = '0;
        end
        for (int d = 0; d < NUM_NODESETS; d++) begin
            for (int s = 0; s < NUM_NODESETS; s++) begin
                cand[d][s]    = i_src_vld[s] && (src_dst[s] == LTW'(d));
                cand_hi[d][s] = cand[d][s] && (PTRW'(s) >= r_ptr[d]);
            end
            pick[d] = (|cand_hi[d]) ? cand_hi[d] : cand[d];
            for (int s = 0; s < NUM_NODESETS; s++) begin
                if (!grant_vld[d] && pick[d][s]) begin
                    grant_vld[d]     = 1'b1;
                    grant_ack[s]     = 1'b1;
                    ptr_nxt[d]       = (s == NUM_NODESETS - 1) ? '0 : PTRW'(s + 1);
                    grant_payload[d] = i_src_payload[s*PW +: PW];
                    grant_lcl[d]     = i_src_nodenum[s*TAGW +: LTW];
                end
            end
        end
    end

    assign o_src_ack = grant_ack | src_bad;
    assign o_idle    = ~|i_src_vld & ~|o_dst_vld;

    // Delivery registers, pointers and sticky bad-tag flag
    always_ff @(posedge clk) begin
        if (rst) begin
            o_dst_vld     <= '0;
            o_dst_payload <= '0;
            o_dst_nodenum <= '0;
            o_bad_tag     <= 1'b0;
            for (int d = 0; d < NUM_NODESETS; d++) begin
                r_ptr[d] <= '0;
            end
        end else begin
            o_dst_vld <= grant_vld;
            for (int d = 0; d < NUM_NODESETS; d++) begin
                if (grant_vld[d]) begin
                    o_dst_payload[d*PW +: PW]   <= grant_payload[d];
                    o_dst_nodenum[d*LTW +: LTW] <= grant_lcl[d];
                    r_ptr[d]                    <= ptr_nxt[d];
                end
            end
            if (|src_bad) begin
                o_bad_tag <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_nodeset_req_router.sv
// Bench for nodeset_req_router: directed scenarios with literal expectations,
// a spec-level arbitration model checked every cycle, and a random soak scoreboard.
`timescale 1ns/1ps
module tb_nodeset_req_router;
    localparam int N   = 8;
    localparam int PDW = 16;
    localparam int PW  = PDW + 2;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   src_vld;
    logic [N*PW-1:0] src_payload;
    logic [N*12-1:0] src_nodenum;
    logic [N-1:0]   src_ack;
    logic [N-1:0]   dst_vld;
    logic [N*PW-1:0] dst_payload;
    logic [N*6-1:0] dst_nodenum;
    logic           idle;
    logic           bad_tag;

    nodeset_req_router #(.NUM_NODESETS(N), .NUM_PATHS_DW(PDW)) dut (
        .clk           (clk),
        .rst           (rst),
        .i_src_vld     (src_vld),
        .i_src_payload (src_payload),
        .i_src_nodenum (src_nodenum),
        .o_src_ack     (src_ack),
        .o_dst_vld     (dst_vld),
        .o_dst_payload (dst_payload),
        .o_dst_nodenum (dst_nodenum),
        .o_idle        (idle),
        .o_bad_tag     (bad_tag)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
        end
    endtask

    function automatic int dest_of(input int k);
        return int'(src_nodenum[k*12+6 +: 6]);
    endfunction

    // Model state: pointer per destination, expected delivery registers
    int            mptr [N];
    logic [N-1:0]  exp_dv = '0;
    logic [PW-1:0] exp_pay [N];
    logic [5:0]    exp_lcl [N];
    logic          exp_bad = 1'b0;
    bit            model_on = 1'b0;
    bit            sb_on = 1'b0;
    logic [N-1:0]  ack_seen = '0;
    int            outstanding [int];

    always @(negedge clk) begin : cmp
        logic [N-1:0] eack;
        logic [N-1:0] gv;
        int           gsrc [N];
        int           s;
        int           id;
        bit           bad_now;
        bit           ok;
        eack    = '0;
        gv      = '0;
        bad_now = 1'b0;
        for (int d = 0; d < N; d++) begin
            gsrc[d] = 0;
            for (int i = 0; i < N; i++) begin
                s = (mptr[d] + i) % N;
                if (!gv[d] && src_vld[s] && dest_of(s) == d) begin
                    gv[d]   = 1'b1;
                    gsrc[d] = s;
                    eack[s] = 1'b1;
                end
            end
        end
        for (int k = 0; k < N; k++) begin
            if (src_vld[k] && dest_of(k) >= N) begin
                eack[k] = 1'b1;
                bad_now = 1'b1;
            end
        end
        ack_seen = src_ack;
        if (model_on) begin
            check("src_ack", src_ack, eack);
            check("dst_vld", dst_vld, exp_dv);
            for (int d = 0; d < N; d++) begin
                if (exp_dv[d]) begin
                    check("dst_payload", dst_payload[d*PW +: PW], exp_pay[d]);
                    check("dst_nodenum", dst_nodenum[d*6 +: 6], exp_lcl[d]);
                end
            end
            check("bad_tag", bad_tag, exp_bad);
            check("idle", idle, (src_vld == '0) && (exp_dv == '0));
            if (sb_on) begin
                for (int d = 0; d < N; d++) begin
                    if (dst_vld[d]) begin
                        id = int'(dst_payload[d*PW +: PW]);
                        ok = outstanding.exists(id) && (outstanding[id] == d);
                        check("sb_deliver_once", ok, 1);
                        if (outstanding.exists(id)) outstanding.delete(id);
                    end
                end
            end
        end
        if (rst) begin
            exp_dv  = '0;
            exp_bad = 1'b0;
            for (int d = 0; d < N; d++) begin
                mptr[d]    = 0;
                exp_pay[d] = '0;
                exp_lcl[d] = '0;
            end
            model_on = 1'b1;
        end else begin
            exp_dv = gv;
            for (int d = 0; d < N; d++) begin
                if (gv[d]) begin
                    exp_pay[d] = src_payload[gsrc[d]*PW +: PW];
                    exp_lcl[d] = src_nodenum[gsrc[d]*12 +: 6];
                    mptr[d]    = (gsrc[d] + 1) % N;
                end
            end
            if (bad_now) exp_bad = 1'b1;
        end
    end

    task automatic send(input int k, input logic [11:0] tag, input logic [PW-1:0] pay);
        src_vld[k]               = 1'b1;
        src_nodenum[k*12 +: 12]  = tag;
        src_payload[k*PW +: PW]  = pay;
    endtask

    // Advance to just after the next rising edge; acked sources drop their request
    task automatic tick();
        @(posedge clk);
        #1;
        src_vld = src_vld & ~ack_seen;
    endtask

    task automatic at_neg();
        @(negedge clk);
        #1;
    endtask

    initial begin : stim
        int id;
        int wait_cnt [N];
        int d;
        logic [11:0] tag;
        src_vld     = '0;
        src_payload = '0;
        src_nodenum = '0;
        for (int k = 0; k < N; k++) wait_cnt[k] = 0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        at_neg();
        check("rst_dst_vld", dst_vld, 8'h00);
        check("rst_bad_tag", bad_tag, 1'b0);
        check("rst_idle", idle, 1'b1);
        check("rst_payload", dst_payload[3*PW +: PW], 18'h0);

        // Single request src2 -> d3
        tick();
        send(2, 12'h0C5, 18'h10004);
        at_neg();
        check("single_ack", src_ack, 8'h04);
        tick();
        at_neg();
        check("single_vld", dst_vld, 8'h08);
        check("single_lcl", dst_nodenum[3*6 +: 6], 6'd5);
        check("single_pay", dst_payload[3*PW +: PW], 18'h10004);

        // Contention on d0 from srcs 1, 4, 6
        tick();
        send(1, 12'h001, 18'h00101);
        send(4, 12'h004, 18'h00404);
        send(6, 12'h006, 18'h00606);
        at_neg();
        check("cont_ack0", src_ack, 8'h02);
        tick();
        at_neg();
        check("cont_ack1", src_ack, 8'h10);
        check("cont_vld1", dst_vld, 8'h01);
        check("cont_pay1", dst_payload[0 +: PW], 18'h00101);
        tick();
        at_neg();
        check("cont_ack2", src_ack, 8'h40);
        check("cont_pay2", dst_payload[0 +: PW], 18'h00404);
        tick();
        at_neg();
        check("cont_ack3", src_ack, 8'h00);
        check("cont_vld3", dst_vld, 8'h01);
        check("cont_lcl3", dst_nodenum[0 +: 6], 6'd6);
        tick();
        at_neg();
        check("cont_drained", dst_vld, 8'h00);
        check("cont_idle", idle, 1'b1);

        // Pointer now 7: src7 beats src0, then wrap to 0
        tick();
        send(0, 12'h010, 18'h00aa0);
        send(7, 12'h017, 18'h00aa7);
        at_neg();
        check("wrap_ack7", src_ack, 8'h80);
        tick();
        at_neg();
        check("wrap_ack0", src_ack, 8'h01);
        check("wrap_pay7", dst_payload[0 +: PW], 18'h00aa7);
        repeat (2) tick();

        // Parallel grants to d5 and d2
        send(0, 12'h140, 18'h05050);
        send(1, 12'h080, 18'h02020);
        send(7, 12'h147, 18'h05757);
        at_neg();
        check("par_ack0", src_ack, 8'h03);
        tick();
        at_neg();
        check("par_vld1", dst_vld, 8'h24);
        check("par_ack1", src_ack, 8'h80);
        check("par_pay_d2", dst_payload[2*PW +: PW], 18'h02020);
        check("par_pay_d5", dst_payload[5*PW +: PW], 18'h05050);
        tick();
        at_neg();
        check("par_vld2", dst_vld, 8'h20);
        check("par_lcl2", dst_nodenum[5*6 +: 6], 6'd7);
        tick();

        // Bad tags: d=63 and boundary d=N
        send(3, 12'hFC1, 18'h3ffff);
        at_neg();
        check("bad_ack", src_ack, 8'h08);
        check("bad_not_yet", bad_tag, 1'b0);
        tick();
        at_neg();
        check("bad_no_dlv", dst_vld, 8'h00);
        check("bad_set", bad_tag, 1'b1);
        tick();
        send(5, 12'h200, 18'h00888);
        at_neg();
        check("bad_ack_n", src_ack, 8'h20);
        repeat (4) tick();
        at_neg();
        check("bad_sticky", bad_tag, 1'b1);
        check("bad_no_dlv2", dst_vld, 8'h00);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        at_neg();
        check("bad_cleared", bad_tag, 1'b0);

        // Reset in the middle of contention
        tick();
        send(1, 12'h001, 18'h00101);
        send(4, 12'h004, 18'h00404);
        send(6, 12'h006, 18'h00606);
        at_neg();
        check("rmid_ack0", src_ack, 8'h02);
        tick();
        rst = 1'b1;
        at_neg();
        check("rmid_ack_rst", src_ack, 8'h10);
        check("rmid_vld_rst", dst_vld, 8'h01);
        tick();
        rst     = 1'b0;
        src_vld = '0;
        send(1, 12'h001, 18'h00101);
        send(4, 12'h004, 18'h00404);
        send(6, 12'h006, 18'h00606);
        at_neg();
        check("rmid_dropped", dst_vld, 8'h00);
        check("rmid_restart", src_ack, 8'h02);
        repeat (5) tick();

        // Random soak to valid destinations
        sb_on = 1'b1;
        id = 0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            @(posedge clk);
            #1;
            for (int k = 0; k < N; k++) begin
                if (src_vld[k]) begin
                    wait_cnt[k]++;
                    if (ack_seen[k]) begin
                        check("fair_wait", wait_cnt[k] <= N, 1);
                        src_vld[k]  = 1'b0;
                        wait_cnt[k] = 0;
                    end
                end
            end
            if (cyc < 9900) begin
                for (int k = 0; k < N; k++) begin
                    if (!src_vld[k] && $urandom_range(0, 1) == 1) begin
                        d   = int'($urandom_range(0, N - 1));
                        tag = {6'(d), 6'($urandom_range(0, 63))};
                        send(k, tag, 18'(id));
                        outstanding[id] = d;
                        id++;
                    end
                end
            end
        end
        check("soak_drained", 64'(outstanding.size()), 0);
        check("soak_idle", idle, 1'b1);
        sb_on = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
